// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and defaults
package uart_pkg;

  // Frame-level states; uart_tx reuses the same encoding.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_IDLE
  } uart_state_e;

  localparam int DEFAULT_CLKS_PER_BIT = 10_000;
  localparam int DATA_BITS            = 8;

endpackage

// File: rtl/baud_counter.sv
// rtl/baud_counter.sv - bit-period counter with wrap and half-point pulses
module baud_counter #(
  parameter int CLKS_PER_BIT = 10_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic wrap_o,
  output logic half_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign wrap_o = en_i && (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
  assign half_o = en_i && (cnt_q == CNT_W'(CLKS_PER_BIT / 2 - 1));

  // Clear wins over counting; the count rolls over at the end of each bit period.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with valid/ready byte output
module uart_rx #(
  parameter int CLKS_PER_BIT = uart_pkg::DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = uart_pkg::DATA_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  import uart_pkg::*;

  localparam int BIT_W = $clog2(DATA_BITS + 1);

  uart_state_e          state_q;
  uart_state_e          state_d;
  logic                 rx_meta_q;
  logic                 rxs_q;
  logic [BIT_W-1:0]     bit_idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q;
  logic                 frame_err_q;
  logic                 overrun_q;

  logic cnt_en;
  logic cnt_clr;
  logic baud_wrap;
  logic baud_half;
  logic shift_en;
  logic frame_good;
  logic frame_bad;

  baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .rst_n (reset),
    .en_i  (cnt_en),
    .clr_i (cnt_clr),
    .wrap_o(baud_wrap),
    .half_o(baud_half)
  );

  // Two-flop synchronizer on the raw line, preset to the idle level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rxs_q     <= rx_meta_q;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and per-cycle control: start qualification, bit sampling, stop check.
  always_comb begin
    state_d    = state_q;
    cnt_en     = 1'b0;
    cnt_clr    = 1'b0;
    shift_en   = 1'b0;
    frame_good = 1'b0;
    frame_bad  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_clr = 1'b1;
        if (!rxs_q) state_d = ST_START;
      end
      ST_START: begin
        cnt_en = 1'b1;
        if (baud_half) begin
          cnt_clr = 1'b1;
          state_d = rxs_q ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        cnt_en = 1'b1;
        if (baud_wrap) begin
          shift_en = 1'b1;
          if (bit_idx_q == BIT_W'(DATA_BITS - 1)) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        cnt_en = 1'b1;
        if (baud_wrap) begin
          if (rxs_q) begin
            frame_good = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            frame_bad  = 1'b1;
            state_d    = ST_WAIT_IDLE;
          end
        end
      end
      ST_WAIT_IDLE: begin
        cnt_clr = 1'b1;
        if (rxs_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Data bits arrive LSB first, so each sample enters at the MSB and shifts down.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else if (state_q == ST_IDLE) begin
      bit_idx_q <= '0;
    end else if (shift_en) begin
      bit_idx_q <= bit_idx_q + 1'b1;
      shift_q   <= {rxs_q, shift_q[DATA_BITS-1:1]};
    end
  end

  // Output holding register: a same-cycle consume makes room for the new byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= frame_bad;
      overrun_q   <= 1'b0;
      if (frame_good) begin
        if (!rx_valid_q || rx_ready) begin
          rx_data_q  <= shift_q;
          rx_valid_q <= 1'b1;
        end else begin
          overrun_q  <= 1'b1;
        end
      end else if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx
module tb_uart_rx;

  localparam int CPB = 16;
  localparam int H   = CPB / 2;

  logic       clk      = 1'b0;
  logic       reset    = 1'b0;
  logic       rx       = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  uart_rx #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: frame decoded from sample instants measured from the first low rxs cycle.
  logic       m_s1 = 1'b1;
  logic       m_rxs = 1'b1;
  int         mode = 0;
  int         pos = 0;
  logic [7:0] m_bits = 8'h00;
  logic       m_v = 1'b0;
  logic [7:0] m_d = 8'h00;
  logic       m_ferr = 1'b0;
  logic       m_ovr = 1'b0;
  logic       cur;
  bit         good;
  bit         badf;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_s1 = 1'b1; m_rxs = 1'b1; mode = 0; pos = 0;
      m_v = 1'b0; m_d = 8'h00; m_ferr = 1'b0; m_ovr = 1'b0;
    end else begin
      good = 0;
      badf = 0;
      cur   = m_rxs;
      m_rxs = m_s1;
      m_s1  = rx;
      case (mode)
        0: if (!cur) begin mode = 1; pos = 1; end
        1: begin
          if (pos == H) begin
            if (cur) mode = 0;
          end else if (pos == H + 9 * CPB) begin
            if (cur) begin good = 1; mode = 0; end
            else begin badf = 1; mode = 2; end
          end else if (pos > H && ((pos - H) % CPB) == 0) begin
            m_bits[(pos - H) / CPB - 1] = cur;
          end
          pos++;
        end
        default: if (cur) mode = 0;
      endcase
      m_ferr = badf;
      m_ovr  = 1'b0;
      if (good) begin
        if (!m_v || rx_ready) begin m_v = 1'b1; m_d = m_bits; end
        else m_ovr = 1'b1;
      end else if (m_v && rx_ready) begin
        m_v = 1'b0;
      end
    end
  end

  bit         cmp_on = 0;
  int         n_rise = 0;
  int         n_vcyc = 0;
  int         n_ferr = 0;
  int         n_ovr  = 0;
  int         last_rise = -1;
  logic [7:0] rise_data = 8'h00;
  logic       prev_v = 1'b0;

  always @(negedge clk) begin
    if (cmp_on) begin
      check("rx_valid", 32'(rx_valid), 32'(m_v));
      check("rx_data", 32'(rx_data), 32'(m_d));
      check("frame_err", 32'(frame_err), 32'(m_ferr));
      check("overrun", 32'(overrun), 32'(m_ovr));
      check("busy", 32'(busy), 32'(mode != 0));
    end
    if (rx_valid) n_vcyc++;
    if (rx_valid && !prev_v) begin
      n_rise++;
      last_rise = cyc;
      rise_data = rx_data;
    end
    if (frame_err) n_ferr++;
    if (overrun) n_ovr++;
    prev_v = rx_valid;
  end

  task automatic clear_counts();
    n_rise = 0; n_vcyc = 0; n_ferr = 0; n_ovr = 0; last_rise = -1;
  endtask

  task automatic drive(input logic b, input int n);
    rx = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    drive(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive(d[i], CPB);
    drive(stop, CPB);
  endtask

  int         k;
  logic [7:0] aborted = 8'hF0;

  initial begin
    reset = 1'b0; rx = 1'b1; rx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    cmp_on = 1;
    reset = 1'b1;
    drive(1'b1, 4);

    // Clean 0xA5 with consumer always ready.
    clear_counts();
    k = cyc;
    send_frame(8'hA5, 1'b1);
    drive(1'b1, 8);
    check("a5_rise_cycle", 32'(last_rise), 32'(k + 155));
    check("a5_data", 32'(rise_data), 32'hA5);
    check("a5_valid_cycles", 32'(n_vcyc), 32'd1);
    check("a5_flags", 32'(n_ferr + n_ovr), 32'd0);

    // Short low glitch is rejected at the mid-start sample.
    clear_counts();
    drive(1'b0, 3);
    drive(1'b1, 40);
    check("glitch_valid", 32'(n_rise), 32'd0);
    check("glitch_flags", 32'(n_ferr + n_ovr), 32'd0);
    check("glitch_busy", 32'(busy), 32'd0);

    // Low stop bit gives a framing error; the next frame still decodes.
    clear_counts();
    send_frame(8'h3C, 1'b0);
    drive(1'b1, 2 * CPB);
    check("ferr_count", 32'(n_ferr), 32'd1);
    check("ferr_no_valid", 32'(n_rise), 32'd0);
    send_frame(8'h55, 1'b1);
    drive(1'b1, 8);
    check("after_ferr_rise", 32'(n_rise), 32'd1);
    check("after_ferr_data", 32'(rise_data), 32'h55);

    // Back-to-back frames with no consumer: first byte held, one overrun.
    rx_ready = 1'b0;
    clear_counts();
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    drive(1'b1, 8);
    check("ovr_valid", 32'(rx_valid), 32'd1);
    check("ovr_data", 32'(rx_data), 32'h11);
    check("ovr_count", 32'(n_ovr), 32'd1);
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
    check("ovr_consumed", 32'(rx_valid), 32'd0);

    // Consume exactly in the completion cycle of the next byte.
    clear_counts();
    send_frame(8'h33, 1'b1);
    drive(1'b1, 4);
    check("hold_33", 32'(rx_data), 32'h33);
    k = cyc;
    fork
      send_frame(8'h77, 1'b1);
      begin
        repeat (154) @(posedge clk);
        #1;
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
        check("swap_cycle", 32'(cyc), 32'(k + 155));
        check("swap_valid", 32'(rx_valid), 32'd1);
        check("swap_data", 32'(rx_data), 32'h77);
      end
    join
    check("swap_no_ovr", 32'(n_ovr), 32'd0);
    rx_ready = 1'b1;
    drive(1'b1, 3);
    check("swap_drained", 32'(rx_valid), 32'd0);

    // Reset in the middle of data bit 4, then a clean frame.
    clear_counts();
    drive(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive(aborted[i], CPB);
    drive(aborted[4], H);
    reset = 1'b0;
    drive(1'b1, 1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_outputs", 32'({rx_valid, frame_err, overrun}), 32'd0);
    check("midrst_data", 32'(rx_data), 32'd0);
    drive(1'b1, 4);
    reset = 1'b1;
    drive(1'b1, 2 * CPB);
    send_frame(8'h0F, 1'b1);
    drive(1'b1, 8);
    check("midrst_rise", 32'(n_rise), 32'd1);
    check("midrst_new_data", 32'(rise_data), 32'h0F);
    check("midrst_flags", 32'(n_ferr + n_ovr), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
